// File: rtl/dht11_responder_pkg.sv
// Shared definitions for the DHT11 responder: FSM state encodings, default
// protocol timings in microseconds, frame length and small helpers.
package dht11_responder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_HOST_LOW  = 4'd1,
        ST_WAIT_REL  = 4'd2,
        ST_RESP_WAIT = 4'd3,
        ST_RESP_LOW  = 4'd4,
        ST_RESP_HIGH = 4'd5,
        ST_BIT_LOW   = 4'd6,
        ST_BIT_HIGH  = 4'd7,
        ST_EOT_LOW   = 4'd8
    } state_e;

    localparam int DEF_TICKS_PER_US = 25;
    localparam int DEF_START_MIN_US = 18000;
    localparam int DEF_RESP_WAIT_US = 30;
    localparam int DEF_RESP_LOW_US  = 80;
    localparam int DEF_RESP_HIGH_US = 80;
    localparam int DEF_BIT_LOW_US   = 50;
    localparam int DEF_BIT0_HIGH_US = 26;
    localparam int DEF_BIT1_HIGH_US = 70;
    localparam int FRAME_BITS       = 40;

    // Checksum byte: plain 8-bit sum of the four data bytes (wraps mod 256).
    function automatic logic [7:0] frame_checksum(input logic [7:0] b0, input logic [7:0] b1,
                                                  input logic [7:0] b2, input logic [7:0] b3);
        return b0 + b1 + b2 + b3;
    endfunction

    // States in which the responder pulls the bus low.
    function automatic logic drives_low(input state_e s);
        return (s == ST_RESP_LOW) || (s == ST_BIT_LOW) || (s == ST_EOT_LOW);
    endfunction

    // States that belong to an accepted frame (start accepted .. end-of-frame low).
    function automatic logic in_frame(input state_e s);
        return (s == ST_RESP_WAIT) || (s == ST_RESP_LOW) || (s == ST_RESP_HIGH) ||
               (s == ST_BIT_LOW)   || (s == ST_BIT_HIGH) || (s == ST_EOT_LOW);
    endfunction

endpackage

// File: rtl/dht11_responder_if.sv
// Bus-side bundle of the DHT11 responder: single-wire line, data bytes and status.
interface dht11_responder_if;
    logic       dht_in;
    logic       dht_oe;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       busy;
    logic       done;

    // Host / environment side: drives line level and measurement data.
    modport master (
        output dht_in, hum_int, hum_dec, temp_int, temp_dec,
        input  dht_oe, busy, done
    );

    // Responder side.
    modport slave (
        input  dht_in, hum_int, hum_dec, temp_int, temp_dec,
        output dht_oe, busy, done
    );
endinterface

// File: rtl/dht11_us_tick.sv
// Microsecond prescaler: emits a one-cycle tick every TICKS_PER_US clocks.
// clr_i restarts the count so the first tick comes a full period later.
module dht11_us_tick #(
    parameter int TICKS_PER_US = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_US - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    // Next prescaler count: clear, wrap at the last tick, or advance.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor-side emulator: detects a host start pulse, answers with the
// preamble and a 40-bit frame (4 data bytes + checksum), MSB first.
// The bus is only ever pulled low; dht_oe comes straight from a register.
module dht11_responder
    import dht11_responder_pkg::*;
#(
    parameter int TICKS_PER_US = DEF_TICKS_PER_US,
    parameter int START_MIN_US = DEF_START_MIN_US,
    parameter int RESP_WAIT_US = DEF_RESP_WAIT_US,
    parameter int RESP_LOW_US  = DEF_RESP_LOW_US,
    parameter int RESP_HIGH_US = DEF_RESP_HIGH_US,
    parameter int BIT_LOW_US   = DEF_BIT_LOW_US,
    parameter int BIT0_HIGH_US = DEF_BIT0_HIGH_US,
    parameter int BIT1_HIGH_US = DEF_BIT1_HIGH_US
) (
    input  logic               clk,
    input  logic               rst,
    dht11_responder_if.slave   bus_if
);
    state_e        state_q, state_d;
    logic [15:0]   us_cnt_q, us_cnt_d;
    logic [5:0]    bit_idx_q, bit_idx_d;
    logic [39:0]   frame_q, frame_d;
    logic          sync1_q, sync2_q;
    logic          oe_q, busy_q, done_q;
    logic          tick;
    logic          clr;
    logic          line_hi;
    logic [15:0]   bit_high_last;

    assign line_hi       = sync2_q;
    assign clr           = (state_d != state_q);
    assign bit_high_last = frame_q[39] ? 16'(BIT1_HIGH_US - 1) : 16'(BIT0_HIGH_US - 1);

    assign bus_if.dht_oe = oe_q;
    assign bus_if.busy   = busy_q;
    assign bus_if.done   = done_q;

    dht11_us_tick #(.TICKS_PER_US(TICKS_PER_US)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .tick_o (tick)
    );

    // Two-flop synchronizer for the asynchronous bus level (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus_if.dht_in;
            sync2_q <= sync1_q;
        end
    end

    // FSM next state, duration counter, bit index and frame shift register.
    // A duration of D us ends on the D-th tick, i.e. exactly D*TICKS_PER_US clocks.
    // Note: right after the end-of-frame low the synced line still reads low for
    // two clocks, so IDLE may briefly enter HOST_LOW and fall straight back.
    always_comb begin
        state_d   = state_q;
        us_cnt_d  = tick ? (us_cnt_q + 16'd1) : us_cnt_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        case (state_q)
            ST_IDLE: begin
                if (!line_hi) state_d = ST_HOST_LOW;
                else          state_d = ST_IDLE;
            end
            ST_HOST_LOW: begin
                if (line_hi)                                           state_d = ST_IDLE;
                else if (tick && us_cnt_q == 16'(START_MIN_US - 1))    state_d = ST_WAIT_REL;
                else                                                   state_d = ST_HOST_LOW;
            end
            ST_WAIT_REL: begin
                if (line_hi) begin
                    frame_d   = {bus_if.hum_int, bus_if.hum_dec, bus_if.temp_int, bus_if.temp_dec,
                                 frame_checksum(bus_if.hum_int, bus_if.hum_dec,
                                                bus_if.temp_int, bus_if.temp_dec)};
                    bit_idx_d = 6'd0;
                    state_d   = ST_RESP_WAIT;
                end else begin
                    state_d = ST_WAIT_REL;
                end
            end
            ST_RESP_WAIT: begin
                if (tick && us_cnt_q == 16'(RESP_WAIT_US - 1)) state_d = ST_RESP_LOW;
                else                                           state_d = ST_RESP_WAIT;
            end
            ST_RESP_LOW: begin
                if (tick && us_cnt_q == 16'(RESP_LOW_US - 1)) state_d = ST_RESP_HIGH;
                else                                          state_d = ST_RESP_LOW;
            end
            ST_RESP_HIGH: begin
                if (tick && us_cnt_q == 16'(RESP_HIGH_US - 1)) state_d = ST_BIT_LOW;
                else                                           state_d = ST_RESP_HIGH;
            end
            ST_BIT_LOW: begin
                if (tick && us_cnt_q == 16'(BIT_LOW_US - 1)) state_d = ST_BIT_HIGH;
                else                                         state_d = ST_BIT_LOW;
            end
            ST_BIT_HIGH: begin
                if (tick && us_cnt_q == bit_high_last) begin
                    frame_d = {frame_q[38:0], 1'b0};
                    if (bit_idx_q == 6'(FRAME_BITS - 1)) begin
                        state_d = ST_EOT_LOW;
                    end else begin
                        bit_idx_d = bit_idx_q + 6'd1;
                        state_d   = ST_BIT_LOW;
                    end
                end else begin
                    state_d = ST_BIT_HIGH;
                end
            end
            ST_EOT_LOW: begin
                if (tick && us_cnt_q == 16'(BIT_LOW_US - 1)) state_d = ST_IDLE;
                else                                         state_d = ST_EOT_LOW;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            us_cnt_d = 16'd0;
        end else begin
            us_cnt_d = us_cnt_d;
        end
    end

    // State, counters and registered bus/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            us_cnt_q  <= 16'd0;
            bit_idx_q <= 6'd0;
            frame_q   <= 40'd0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            us_cnt_q  <= us_cnt_d;
            bit_idx_q <= bit_idx_d;
            frame_q   <= frame_d;
            oe_q      <= drives_low(state_d);
            busy_q    <= in_frame(state_d);
            done_q    <= (state_q == ST_EOT_LOW) && (state_d == ST_IDLE);
        end
    end
endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder: models the pull-up and a host driver,
// times every responder low/high phase and decodes the frame.
module tb_dht11_responder;
    localparam int TPU = 2;

    logic clk = 1'b0;
    logic rst;
    logic host_low;
    int   n_pass = 0;
    int   n_chk  = 0;

    dht11_responder_if bus_if();

    // Open-drain bus with pull-up: low if either side pulls.
    assign bus_if.dht_in = ~(bus_if.dht_oe | host_low);

    dht11_responder #(.TICKS_PER_US(TPU), .START_MIN_US(20)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        int          low_us;
        bit          resp;
        logic [39:0] frame;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_data(input logic [31:0] d);
        bus_if.hum_int  = d[31:24];
        bus_if.hum_dec  = d[23:16];
        bus_if.temp_int = d[15:8];
        bus_if.temp_dec = d[7:0];
    endtask

    // Host start pulse; called and returns on a negedge.
    task automatic host_pulse(input int us);
        host_low = 1'b1;
        repeat (us * TPU) @(negedge clk);
        host_low = 1'b0;
    endtask

    // Number of consecutive negedge samples (starting now) with dht_oe == level.
    task automatic measure(input logic level, input int limit, output int n);
        if (bus_if.dht_oe !== level) begin
            n = 0;
        end else begin
            n = 1;
            while (n < limit) begin
                @(negedge clk);
                if (bus_if.dht_oe !== level) break;
                n++;
            end
        end
    endtask

    // Follows one whole response starting at host release and checks every phase.
    task automatic run_frame(input string tag, input logic [39:0] exp);
        int w;
        int n;
        logic [39:0] got;
        got = 40'd0;
        w = 0;
        while (bus_if.dht_oe !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check({tag, " resp_wait"}, 64'(w), 64'd63);
        check({tag, " busy_in_frame"}, 64'(bus_if.busy), 64'd1);
        measure(1'b1, 400, n);
        check({tag, " pre_low"}, 64'(n), 64'd160);
        measure(1'b0, 400, n);
        check({tag, " pre_high"}, 64'(n), 64'd160);
        for (int i = 0; i < 40; i++) begin
            measure(1'b1, 400, n);
            check($sformatf("%s bit%0d_low", tag, i), 64'(n), 64'd100);
            measure(1'b0, 400, n);
            got = {got[38:0], (n > 96)};
            check($sformatf("%s bit%0d_high", tag, i), 64'(n), exp[39 - i] ? 64'd140 : 64'd52);
        end
        measure(1'b1, 400, n);
        check({tag, " eot_low"}, 64'(n), 64'd100);
        check({tag, " done_pulse"}, 64'(bus_if.done), 64'd1);
        check({tag, " busy_end"}, 64'(bus_if.busy), 64'd0);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 64'(bus_if.done), 64'd0);
        check({tag, " frame"}, 64'(got), 64'(exp));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[4];
        int   seen_oe;
        int   seen_busy;
        int   rises;
        int   cyc;
        logic prev;

        vecs[0] = '{name: "mixed",  data: 32'h37001905, low_us: 25, resp: 1'b1, frame: 40'h37_00_19_05_55};
        vecs[1] = '{name: "glitch", data: 32'h37001905, low_us: 10, resp: 1'b0, frame: 40'h0};
        vecs[2] = '{name: "ones",   data: 32'hFFFFFFFF, low_us: 25, resp: 1'b1, frame: 40'hFF_FF_FF_FF_FC};
        vecs[3] = '{name: "zeros",  data: 32'h00000000, low_us: 25, resp: 1'b1, frame: 40'h00_00_00_00_00};

        rst      = 1'b1;
        host_low = 1'b0;
        set_data(32'h0);
        repeat (3) @(negedge clk);
        check("reset oe", 64'(bus_if.dht_oe), 64'd0);
        check("reset busy", 64'(bus_if.busy), 64'd0);
        check("reset done", 64'(bus_if.done), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            set_data(vecs[v].data);
            host_pulse(vecs[v].low_us);
            if (vecs[v].resp) begin
                run_frame(vecs[v].name, vecs[v].frame);
            end else begin
                seen_oe   = 0;
                seen_busy = 0;
                repeat (300) begin
                    @(negedge clk);
                    if (bus_if.dht_oe === 1'b1) seen_oe++;
                    if (bus_if.busy === 1'b1)   seen_busy++;
                end
                check({vecs[v].name, " oe_never"}, 64'(seen_oe), 64'd0);
                check({vecs[v].name, " busy_never"}, 64'(seen_busy), 64'd0);
            end
            repeat (20) @(negedge clk);
        end

        // Reset in the low phase of bit 17 releases the bus at once.
        set_data(32'h12345678);
        host_pulse(25);
        rises = 0;
        cyc   = 0;
        prev  = 1'b0;
        while (rises < 19 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (bus_if.dht_oe === 1'b1 && prev === 1'b0) rises++;
            prev = bus_if.dht_oe;
        end
        check("midrst reached_bit17", 64'(rises), 64'd19);
        repeat (20) @(negedge clk);
        check("midrst oe_before", 64'(bus_if.dht_oe), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst oe_async", 64'(bus_if.dht_oe), 64'd0);
        check("midrst busy_async", 64'(bus_if.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst oe_after", 64'(bus_if.dht_oe), 64'd0);
        set_data(32'hA55AC33C);
        host_pulse(25);
        run_frame("after_rst", 40'hA5_5A_C3_3C_FE);
        repeat (20) @(negedge clk);

        // Host activity and data changes during a frame must not disturb it.
        set_data(32'h01020304);
        host_pulse(25);
        fork
            run_frame("noisy", 40'h01_02_03_04_0A);
            begin
                repeat (700) @(negedge clk);
                host_low = 1'b1;
                set_data(32'hDEADBEEF);
                repeat (50) @(negedge clk);
                host_low = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        set_data(32'h28001A00);
        host_pulse(25);
        run_frame("second", 40'h28_00_1A_00_42);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
